// File: rtl/conv_pkg.sv
// Shared constants for the 32b<->10b gearbox pair.
// Five 32-bit words carry exactly sixteen 10-bit symbols.
package conv_pkg;

  localparam int CONV_SYM_W       = 10;
  localparam int CONV_WORD_W      = 32;
  localparam int CONV_BUF_W       = 48;
  localparam int CONV_ALIGN_WORDS = 5;
  localparam int CONV_ALIGN_SYMS  = 16;
  localparam int CONV_ALIGN_BITS  = CONV_ALIGN_WORDS * CONV_WORD_W;

  // Width of a counter that must hold values 0..buf_w inclusive.
  function automatic int conv_cnt_w(input int buf_w);
    return $clog2(buf_w + 1);
  endfunction

endpackage

// File: rtl/conv32bto10b_chk.sv
// Property checker for the 32b->10b gearbox: counter bound, output hold
// under stall, and no accepted word while the block reports not-ready.
module conv32bto10b_chk
  import conv_pkg::*;
#(
  parameter int OUT_W = CONV_SYM_W,
  parameter int BUF_W = CONV_BUF_W,
  parameter int CNT_W = conv_cnt_w(CONV_BUF_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cnt_q,
  input  logic             i_rdy,
  input  logic             o_vld,
  input  logic             o_rdy,
  input  logic [OUT_W-1:0] o_dat
);

  // Counter never exceeds the buffer.
  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
    cnt_q <= CNT_W'(BUF_W));

  // A stalled symbol stays valid and unchanged.
  a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (o_vld && !o_rdy) |=> (o_vld && $stable(o_dat)));

  // While not ready, the counter may only fall or hold.
  a_no_push: assert property (@(posedge clk) disable iff (!rst_n)
    !i_rdy |=> (cnt_q <= $past(cnt_q)));

endmodule

// File: rtl/conv32bto10b.sv
// Transmit gearbox: 32-bit words in over valid/ready, contiguous MSB-first
// 10-bit symbols out under backpressure.
module conv32bto10b
  import conv_pkg::*;
#(
  parameter int IN_W  = CONV_WORD_W,
  parameter int OUT_W = CONV_SYM_W,
  parameter int BUF_W = CONV_BUF_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_vld,
  input  logic [IN_W-1:0]  i_dat,
  output logic             i_rdy,
  input  logic             i_flush,
  output logic             o_vld,
  output logic [OUT_W-1:0] o_dat,
  input  logic             o_rdy
);

  localparam int CNT_W = conv_cnt_w(BUF_W);
  localparam logic [CNT_W-1:0] IN_C  = CNT_W'(IN_W);
  localparam logic [CNT_W-1:0] OUT_C = CNT_W'(OUT_W);
  localparam logic [CNT_W-1:0] RDY_C = CNT_W'(BUF_W - IN_W);

  logic [BUF_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BUF_W-1:0] sel_s;
  logic             push_s, pop_s, flush_s;

  // Handshake flags and the oldest OUT_W valid bits, all from flops only.
  always_comb begin
    o_vld   = (cnt_q >= OUT_C);
    i_rdy   = (cnt_q <= RDY_C);
    push_s  = i_vld & i_rdy;
    pop_s   = o_vld & o_rdy;
    flush_s = i_flush & ~push_s & (cnt_q != {CNT_W{1'b0}}) & (cnt_q < OUT_C);
    if (o_vld) begin
      sel_s = buf_q >> (cnt_q - OUT_C);
    end else begin
      sel_s = {BUF_W{1'b0}};
    end
    o_dat = sel_s[OUT_W-1:0];
  end

  // Popped bits sit above the new count, so a pop never touches the buffer.
  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (push_s) begin
      buf_d = {buf_q[BUF_W-IN_W-1:0], i_dat};
      if (pop_s) begin
        cnt_d = cnt_q + IN_C - OUT_C;
      end else begin
        cnt_d = cnt_q + IN_C;
      end
    end else if (pop_s) begin
      cnt_d = cnt_q - OUT_C;
    end else if (flush_s) begin
      buf_d = buf_q << (OUT_C - cnt_q);
      cnt_d = OUT_C;
    end else begin
      buf_d = buf_q;
      cnt_d = cnt_q;
    end
  end

  // Residue buffer and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= {BUF_W{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_conv32bto10b.sv
// Directed self-checking bench for the 32b->10b gearbox.
module tb_conv32bto10b;
  import conv_pkg::*;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b1;
  logic        i_vld   = 1'b0;
  logic [31:0] i_dat   = 32'h0;
  logic        i_flush = 1'b0;
  logic        o_rdy   = 1'b0;
  logic        i_rdy;
  logic        o_vld;
  logic [9:0]  o_dat;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  conv32bto10b dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_vld   (i_vld),
    .i_dat   (i_dat),
    .i_rdy   (i_rdy),
    .i_flush (i_flush),
    .o_vld   (o_vld),
    .o_dat   (o_dat),
    .o_rdy   (o_rdy)
  );

  conv32bto10b_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .cnt_q (dut.cnt_q),
    .i_rdy (i_rdy),
    .o_vld (o_vld),
    .o_rdy (o_rdy),
    .o_dat (o_dat)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0]  words [CONV_ALIGN_WORDS];
    logic [CONV_ALIGN_BITS-1:0] stream;
    logic [CONV_ALIGN_BITS-1:0] tmp;
    int wi;
    int si;
    logic fired;

    // reset
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_cnt", 64'(dut.cnt_q), 64'd0);
    check_eq("rst_ovld", 64'(o_vld), 64'd0);
    check_eq("rst_irdy", 64'(i_rdy), 64'd1);
    step();
    step();
    rst_n = 1'b1;
    step();

    // test 1: single word, full-rate drain
    o_rdy = 1'b1;
    i_vld = 1'b1;
    i_dat = 32'hFFC0_0001;
    step();
    i_vld = 1'b0;
    check_eq("t1_vld0", 64'(o_vld), 64'd1);
    check_eq("t1_sym0", 64'(o_dat), 64'h3FF);
    step();
    check_eq("t1_sym1", 64'(o_dat), 64'h000);
    step();
    check_eq("t1_sym2", 64'(o_dat), 64'h000);
    step();
    check_eq("t1_cnt", 64'(dut.cnt_q), 64'd2);
    check_eq("t1_ovld", 64'(o_vld), 64'd0);

    // test 4: flush the 2'b01 residue
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    check_eq("t4_vld", 64'(o_vld), 64'd1);
    check_eq("t4_sym", 64'(o_dat), 64'h100);
    check_eq("t4_cnt10", 64'(dut.cnt_q), 64'd10);
    step();
    check_eq("t4_cnt0", 64'(dut.cnt_q), 64'd0);
    check_eq("t4_ovld", 64'(o_vld), 64'd0);

    // test 2: five words map onto sixteen symbols
    words[0] = 32'h0123_4567;
    words[1] = 32'h89AB_CDEF;
    words[2] = 32'hFEDC_BA98;
    words[3] = 32'h7654_3210;
    words[4] = 32'hDEAD_BEEF;
    stream = {words[0], words[1], words[2], words[3], words[4]};
    wi = 0;
    si = 0;
    o_rdy = 1'b1;
    for (int c = 0; c < 60 && si < CONV_ALIGN_SYMS; c++) begin
      if (wi < CONV_ALIGN_WORDS) begin
        i_vld = 1'b1;
        i_dat = words[wi];
      end else begin
        i_vld = 1'b0;
      end
      fired = i_vld && i_rdy;
      if (o_vld) begin
        tmp = stream >> (CONV_ALIGN_BITS - CONV_SYM_W - CONV_SYM_W * si);
        check_eq($sformatf("t2_sym%0d", si), 64'(o_dat), 64'(tmp[9:0]));
        si++;
      end
      step();
      if (fired) wi++;
    end
    i_vld = 1'b0;
    check_eq("t2_nsym", 64'(si), 64'(CONV_ALIGN_SYMS));
    check_eq("t2_nword", 64'(wi), 64'(CONV_ALIGN_WORDS));
    check_eq("t2_cnt", 64'(dut.cnt_q), 64'd0);

    // flush with nothing buffered is ignored
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    check_eq("fl0_cnt", 64'(dut.cnt_q), 64'd0);
    check_eq("fl0_ovld", 64'(o_vld), 64'd0);

    // test 3: stalled output, one word accepted, symbol held
    o_rdy = 1'b0;
    i_vld = 1'b1;
    i_dat = 32'hA5A5_F00F;
    step();
    check_eq("t3_cnt", 64'(dut.cnt_q), 64'd32);
    check_eq("t3_irdy", 64'(i_rdy), 64'd0);
    check_eq("t3_sym0", 64'(o_dat), 64'h296);
    step();
    step();
    step();
    check_eq("t3_hcnt", 64'(dut.cnt_q), 64'd32);
    check_eq("t3_hold", 64'(o_dat), 64'h296);
    i_vld = 1'b0;
    o_rdy = 1'b1;
    step();
    check_eq("t3_sym1", 64'(o_dat), 64'h25F);
    step();
    check_eq("t3_sym2", 64'(o_dat), 64'h003);
    step();
    check_eq("t3_cnt2", 64'(dut.cnt_q), 64'd2);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    check_eq("t3_flsym", 64'(o_dat), 64'h300);
    check_eq("t3_flcnt", 64'(dut.cnt_q), 64'd10);

    // test 5: push and pop together at cnt=10
    i_vld = 1'b1;
    i_dat = 32'h1234_5678;
    step();
    i_vld = 1'b0;
    check_eq("t5_cnt", 64'(dut.cnt_q), 64'd32);
    check_eq("t5_sym0", 64'(o_dat), 64'h048);
    step();
    check_eq("t5_sym1", 64'(o_dat), 64'h345);

    // flush while a full symbol is buffered is ignored
    o_rdy = 1'b0;
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    check_eq("t5_flcnt", 64'(dut.cnt_q), 64'd22);
    check_eq("t5_flsym", 64'(o_dat), 64'h345);

    // test 6: async reset mid-stall
    rst_n = 1'b0;
    #1;
    check_eq("t6_ovld", 64'(o_vld), 64'd0);
    check_eq("t6_irdy", 64'(i_rdy), 64'd1);
    check_eq("t6_cnt", 64'(dut.cnt_q), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    check_eq("t6_idle", 64'(o_vld), 64'd0);
    o_rdy = 1'b1;
    i_vld = 1'b1;
    i_dat = 32'h8000_0001;
    step();
    i_vld = 1'b0;
    check_eq("t6_sym0", 64'(o_dat), 64'h200);
    step();
    check_eq("t6_sym1", 64'(o_dat), 64'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
